wt_wbuf_coalesce: RTL and testbench

Parametrised write-through store buffer between the load/store unit and the write-through data cache memory port. It replaces the fixed-depth store path with a configurable buffer of Depth word entries that issues stores in order under a limited outstanding-transaction budget. Each issued store is tagged with a transaction ID and retired on a tagged acknowledge. An optional byte-merge mode coalesces stores to a not-yet-issued word. A probe port reports address hazards to the load path.

---
 rtl/wt_wbuf_coalesce.sv | 203 ++++++++++++++++++++
 tb/tb_wt_wbuf_coalesce.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_wbuf_coalesce.sv
// Write-through store buffer: in-order issue to the cache port under a TID budget, tagged out-of-order acks, in-order retire.
// Define WT_WBUF_COALESCE_EN to merge stores into a not-yet-issued entry with the same word address.
module wt_wbuf_coalesce #(
  parameter int Xlen      = 32,
  parameter int AddrWidth = 32,
  parameter int Depth     = 8,
  parameter int TidWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [Xlen-1:0]      req_data_i,
  input  logic [Xlen/8-1:0]    req_be_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [Xlen-1:0]      mem_data_o,
  output logic [Xlen/8-1:0]    mem_be_o,
  output logic [TidWidth-1:0]  mem_tid_o,
  input  logic                 ack_valid_i,
  input  logic [TidWidth-1:0]  ack_tid_i,
  input  logic [AddrWidth-1:0] probe_addr_i,
  output logic                 probe_hit_o,
  output logic                 empty_o,
  output logic                 full_o
);
  localparam int BeW    = Xlen / 8;
  localparam int OffW   = $clog2(BeW);
  localparam int WordW  = AddrWidth - OffW;
  localparam int IdxW   = $clog2(Depth);
  localparam int PtrW   = IdxW + 1;
  localparam int NumTid = 2 ** TidWidth;

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_INFL, ST_DONE} ent_state_e;

  ent_state_e          state_q [Depth];
  ent_state_e          state_d [Depth];
  logic [WordW-1:0]    addr_q  [Depth];
  logic [WordW-1:0]    addr_d  [Depth];
  logic [Xlen-1:0]     data_q  [Depth];
  logic [Xlen-1:0]     data_d  [Depth];
  logic [BeW-1:0]      be_q    [Depth];
  logic [BeW-1:0]      be_d    [Depth];
  logic [TidWidth-1:0] tid_q   [Depth];
  logic [TidWidth-1:0] tid_d   [Depth];
  logic [PtrW-1:0]     head_q, head_d, issue_q, issue_d, tail_q, tail_d;
  logic [NumTid-1:0]   busy_q, busy_d;
  logic                offer_q, offer_d;
  logic [TidWidth-1:0] offer_tid_q, offer_tid_d;

  logic [PtrW-1:0]     count;
  logic [IdxW-1:0]     head_idx, issue_idx, tail_idx;
  logic [WordW-1:0]    req_word, probe_word;
  logic [TidWidth-1:0] free_tid, issue_tid;
  logic                tid_avail, mem_hs, has_room, alloc, merge_hit;
  logic [IdxW-1:0]     merge_idx;
  logic                unused_addr_bits;

  assign count      = tail_q - head_q;
  assign head_idx   = head_q[IdxW-1:0];
  assign issue_idx  = issue_q[IdxW-1:0];
  assign tail_idx   = tail_q[IdxW-1:0];
  assign req_word   = req_addr_i[AddrWidth-1:OffW];
  assign probe_word = probe_addr_i[AddrWidth-1:OffW];
  assign has_room   = count < PtrW'(Depth);
  assign full_o     = count == PtrW'(Depth);
  assign empty_o    = count == '0;
  assign unused_addr_bits = ^{req_addr_i[OffW-1:0], probe_addr_i[OffW-1:0]};

  always_comb begin
    probe_hit_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if ((state_q[i] == ST_PEND || state_q[i] == ST_INFL) && addr_q[i] == probe_word) begin
        probe_hit_o = 1'b1;
      end
    end
  end

  // A TID offered but not yet accepted is held so mem_tid_o cannot shift under a stall.
  always_comb begin
    free_tid  = '0;
    tid_avail = 1'b0;
    for (int t = NumTid - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        free_tid  = TidWidth'(t);
        tid_avail = 1'b1;
      end
    end
    issue_tid   = offer_q ? offer_tid_q : free_tid;
    mem_valid_o = (state_q[issue_idx] == ST_PEND) && (offer_q || tid_avail);
    mem_hs      = mem_valid_o && mem_ready_i;
    mem_addr_o  = mem_valid_o ? {addr_q[issue_idx], {OffW{1'b0}}} : '0;
    mem_data_o  = mem_valid_o ? data_q[issue_idx] : '0;
    mem_be_o    = mem_valid_o ? be_q[issue_idx] : '0;
    mem_tid_o   = mem_valid_o ? issue_tid : '0;
  end

`ifdef WT_WBUF_COALESCE_EN
  // The entry completing its handshake this cycle is already on the bus and cannot absorb data.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < Depth; i++) begin
      if (state_q[i] == ST_PEND && addr_q[i] == req_word &&
          !(mem_hs && i == int'(issue_idx))) begin
        merge_hit = 1'b1;
        merge_idx = IdxW'(i);
      end
    end
  end
  assign req_ready_o = has_room || merge_hit;
  assign alloc       = req_valid_i && !merge_hit && has_room && (req_be_i != '0);
`else
  assign merge_hit   = 1'b0;
  assign merge_idx   = '0;
  assign req_ready_o = has_room;
  assign alloc       = req_valid_i && has_room && (req_be_i != '0);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    be_d        = be_q;
    tid_d       = tid_q;
    head_d      = head_q;
    issue_d     = issue_q;
    tail_d      = tail_q;
    busy_d      = busy_q;
    offer_d     = mem_valid_o && !mem_ready_i;
    offer_tid_d = issue_tid;

    if (ack_valid_i && busy_q[ack_tid_i]) begin
      busy_d[ack_tid_i] = 1'b0;
      for (int i = 0; i < Depth; i++) begin
        if (state_q[i] == ST_INFL && tid_q[i] == ack_tid_i) begin
          state_d[i] = ST_DONE;
        end
      end
    end

    if (state_q[head_idx] == ST_DONE) begin
      state_d[head_idx] = ST_FREE;
      head_d            = head_q + 1'b1;
    end

    if (mem_hs) begin
      state_d[issue_idx] = ST_INFL;
      tid_d[issue_idx]   = issue_tid;
      busy_d[issue_tid]  = 1'b1;
      issue_d            = issue_q + 1'b1;
    end

    if (req_valid_i && merge_hit) begin
      for (int b = 0; b < BeW; b++) begin
        if (req_be_i[b]) begin
          data_d[merge_idx][8*b +: 8] = req_data_i[8*b +: 8];
        end
      end
      be_d[merge_idx] = be_q[merge_idx] | req_be_i;
    end

    if (alloc) begin
      state_d[tail_idx] = ST_PEND;
      addr_d[tail_idx]  = req_word;
      data_d[tail_idx]  = req_data_i;
      be_d[tail_idx]    = req_be_i;
      tail_d            = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        state_q[i] <= ST_FREE;
      end
      head_q      <= '0;
      issue_q     <= '0;
      tail_q      <= '0;
      busy_q      <= '0;
      offer_q     <= 1'b0;
      offer_tid_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      issue_q     <= issue_d;
      tail_q      <= tail_d;
      busy_q      <= busy_d;
      offer_q     <= offer_d;
      offer_tid_q <= offer_tid_d;
    end
  end

  // Payload is only meaningful under a live state, so it carries no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
    tid_q  <= tid_d;
  end
endmodule

// File: tb/tb_wt_wbuf_coalesce.sv
// Directed self-checking bench for wt_wbuf_coalesce (default parameters); merge-mode expectations
// follow WT_WBUF_COALESCE_EN when it is defined for the build.
module tb_wt_wbuf_coalesce;
  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic [3:0]  reqBe;
  logic        memValid;
  logic        memReady;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [3:0]  memBe;
  logic [1:0]  memTid;
  logic        ackValid;
  logic [1:0]  ackTid;
  logic [31:0] probeAddr;
  logic        probeHit;
  logic        empty;
  logic        full;

  int totalCount = 0;
  int badCount   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  tid;
  } hs_t;
  hs_t hsQ[$];

  wt_wbuf_coalesce dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
    .req_data_i(reqData), .req_be_i(reqBe),
    .mem_valid_o(memValid), .mem_ready_i(memReady), .mem_addr_o(memAddr),
    .mem_data_o(memData), .mem_be_o(memBe), .mem_tid_o(memTid),
    .ack_valid_i(ackValid), .ack_tid_i(ackTid),
    .probe_addr_i(probeAddr), .probe_hit_o(probeHit),
    .empty_o(empty), .full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted memory write; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (!rst && memValid && memReady) begin
      hsQ.push_back('{addr: memAddr, data: memData, be: memBe, tid: memTid});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic rdy, input logic ackV,
                               input logic [1:0] ackT);
    reqValid = valid;
    reqAddr  = addr;
    reqData  = data;
    reqBe    = be;
    memReady = rdy;
    ackValid = ackV;
    ackTid   = ackT;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    hsQ.delete();
  endtask

  function automatic logic [63:0] hsTid(input int k);
    if (k < hsQ.size()) return 64'(hsQ[k].tid);
    return 64'hDEAD;
  endfunction

  function automatic logic [63:0] hsData(input int k);
    if (k < hsQ.size()) return 64'(hsQ[k].data);
    return 64'hDEAD;
  endfunction

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "Ready"}, 64'(reqReady), 64'd1);
    checkOutput({pfx, "Valid"}, 64'(memValid), 64'd0);
    checkOutput({pfx, "Addr"},  64'(memAddr),  64'd0);
    checkOutput({pfx, "Data"},  64'(memData),  64'd0);
    checkOutput({pfx, "Be"},    64'(memBe),    64'd0);
    checkOutput({pfx, "Tid"},   64'(memTid),   64'd0);
    checkOutput({pfx, "Probe"}, 64'(probeHit), 64'd0);
    checkOutput({pfx, "Empty"}, 64'(empty),    64'd1);
    checkOutput({pfx, "Full"},  64'(full),     64'd0);
  endtask

  initial begin
    probeAddr = 32'h100;
    resetDut();

    // Single store: issue next cycle with tid 0, retire two cycles after its ack.
    @(negedge clk);
    checkResetOutputs("rst");
    step();
    applyStimulus(1, 32'h100, 32'hAABBCCDD, 4'hF, 1, 0, 0);
    @(negedge clk);
    checkOutput("t1Ready", 64'(reqReady), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t1Valid", 64'(memValid), 64'd1);
    checkOutput("t1Addr",  64'(memAddr),  64'h100);
    checkOutput("t1Data",  64'(memData),  64'hAABBCCDD);
    checkOutput("t1Be",    64'(memBe),    64'hF);
    checkOutput("t1Tid",   64'(memTid),   64'd0);
    checkOutput("t1ProbePend", 64'(probeHit), 64'd1);
    checkOutput("t1NotEmpty",  64'(empty),    64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 1, 2'd0);
    @(negedge clk);
    checkOutput("t1ValidLow",  64'(memValid), 64'd0);
    checkOutput("t1ProbeInfl", 64'(probeHit), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t1EmptyDone", 64'(empty),    64'd0);
    checkOutput("t1ProbeDone", 64'(probeHit), 64'd0);
    step();
    @(negedge clk);
    checkOutput("t1Empty", 64'(empty), 64'd1);
    step();

    // Fill with no acks: four issue on tids 0..3, then an ack of tid 2 lets the fifth go.
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 32'h1000 + 32'(4 * i), 32'(i), 4'hF, 1, 0, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    checkOutput("t2Issued", 64'(hsQ.size()), 64'd4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("t2Tid%0d", k), hsTid(k), 64'(k));
    @(negedge clk);
    checkOutput("t2Full",    64'(full),     64'd1);
    checkOutput("t2NoReady", 64'(reqReady), 64'd0);
    checkOutput("t2Starved", 64'(memValid), 64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 1, 2'd2);
    @(negedge clk);
    checkOutput("t2AckCycle", 64'(memValid), 64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t2FifthValid", 64'(memValid), 64'd1);
    checkOutput("t2FifthTid",   64'(memTid),   64'd2);
    checkOutput("t2FifthAddr",  64'(memAddr),  64'h1010);
    step();
    checkOutput("t2Issued5", 64'(hsQ.size()), 64'd5);
    checkOutput("t2Tid4",    hsTid(4),        64'd2);

    // Out-of-order acks 3,1,0,2: retire waits for the head, then one per cycle.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h2000 + 32'(4 * i), 32'h50 + 32'(i), 4'hF, 1, 0, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    checkOutput("t3Issued", 64'(hsQ.size()), 64'd4);
    probeAddr = 32'h2004;
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd3);
    @(negedge clk);
    checkOutput("t3ProbeA", 64'(probeHit), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd1);
    @(negedge clk);
    checkOutput("t3ProbeB", 64'(probeHit), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd0);
    @(negedge clk);
    checkOutput("t3ProbeAcked", 64'(probeHit), 64'd0);
    checkOutput("t3HeadWait",   64'(empty),    64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 1, 2'd2);
    @(negedge clk);
    checkOutput("t3EmptyX4", 64'(empty), 64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    @(negedge clk);
    checkOutput("t3EmptyX7", 64'(empty), 64'd0);
    step();
    @(negedge clk);
    checkOutput("t3EmptyX8", 64'(empty), 64'd1);
    step();

    // Two partial stores to 0x200 while the port is stalled.
    resetDut();
    applyStimulus(1, 32'h200, 32'h00001111, 4'h3, 0, 0, 0);
    step();
    applyStimulus(1, 32'h200, 32'h22220000, 4'hC, 0, 0, 0);
    @(negedge clk);
    checkOutput("t4Ready", 64'(reqReady), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t4Valid", 64'(memValid), 64'd1);
    checkOutput("t4Addr",  64'(memAddr),  64'h200);
    checkOutput("t4Tid",   64'(memTid),   64'd0);
`ifdef WT_WBUF_COALESCE_EN
    checkOutput("t4Data", 64'(memData), 64'h22221111);
    checkOutput("t4Be",   64'(memBe),   64'hF);
`else
    checkOutput("t4Data", 64'(memData), 64'h00001111);
    checkOutput("t4Be",   64'(memBe),   64'h3);
`endif
    step();
    @(negedge clk);
`ifdef WT_WBUF_COALESCE_EN
    checkOutput("t4NoSecond", 64'(memValid), 64'd0);
`else
    checkOutput("t4Second",     64'(memValid), 64'd1);
    checkOutput("t4SecondData", 64'(memData),  64'h22220000);
    checkOutput("t4SecondBe",   64'(memBe),    64'hC);
    checkOutput("t4SecondTid",  64'(memTid),   64'd1);
`endif
    step();
`ifdef WT_WBUF_COALESCE_EN
    checkOutput("t4Count", 64'(hsQ.size()), 64'd1);
`else
    checkOutput("t4Count", 64'(hsQ.size()), 64'd2);
`endif

`ifdef WT_WBUF_COALESCE_EN
    // Merge into a pending entry while full; a store to the entry in its handshake cycle cannot merge.
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 32'h3000 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i), 4'hF, 0, 0, 0);
      step();
    end
    applyStimulus(1, 32'h3008, 32'h00000055, 4'h1, 0, 0, 0);
    @(negedge clk);
    checkOutput("t5Full",       64'(full),     64'd1);
    checkOutput("t5MergeReady", 64'(reqReady), 64'd1);
    step();
    applyStimulus(1, 32'h3000, 32'h00000077, 4'hF, 1, 0, 0);
    @(negedge clk);
    checkOutput("t5HsNoMerge", 64'(reqReady), 64'd0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    repeat (5) step();
    checkOutput("t5Issued", 64'(hsQ.size()), 64'd4);
    checkOutput("t5Data0",  hsData(0),       64'hA0A0A0A0);
    checkOutput("t5Data2",  hsData(2),       64'hA0A0A055);
`endif

    // A store landing on the entry in its handshake cycle allocates a fresh entry.
    resetDut();
    applyStimulus(1, 32'h4000, 32'h11, 4'hF, 0, 0, 0);
    step();
    applyStimulus(1, 32'h4000, 32'h22, 4'hF, 1, 0, 0);
    @(negedge clk);
    checkOutput("t5bReady", 64'(reqReady), 64'd1);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t5bValid", 64'(memValid), 64'd1);
    checkOutput("t5bData",  64'(memData),  64'h22);
    checkOutput("t5bTid",   64'(memTid),   64'd1);
    step();
    checkOutput("t5bFirstData", hsData(0), 64'h11);

    // Reset with three writes in flight: later acks are unknown and ignored.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h5000 + 32'(4 * i), 32'h99, 4'hF, 1, 0, 0);
      step();
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    checkOutput("t6Issued", 64'(hsQ.size()), 64'd3);
    probeAddr = 32'h5000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("t6");
    for (int t = 0; t < 3; t++) begin
      step();
      applyStimulus(0, 0, 0, 0, 1, 1, 2'(t));
    end
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t6AckEmpty", 64'(empty),    64'd1);
    checkOutput("t6AckValid", 64'(memValid), 64'd0);
    step();
    applyStimulus(1, 32'h6000, 32'h1, 4'hF, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("t6NewValid", 64'(memValid), 64'd1);
    checkOutput("t6NewTid",   64'(memTid),   64'd0);
    checkOutput("t6NewAddr",  64'(memAddr),  64'h6000);
    step();

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end
endmodule
